// File: rtl/lockin_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : lockin_multicanal
// Purpose  : Multi-channel lock-in core. NCH time-multiplexed channels share
//            one sin/cos reference. Each channel accumulates sample*sin and
//            sample*cos over M points x N frames. Per-channel results leave
//            on a back-pressured stream.
// Revision : 1.0 - initial release
// ============================================================================
module lockin_multicanal #(
  parameter int DATA_W = 32,
  parameter int REF_W  = 16,
  parameter int ACC_W  = 64,
  parameter int NCH    = 2,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     mode_continuous,
  input  logic [CNT_W-1:0]         ptos_x_ciclo,
  input  logic [CNT_W-1:0]         frames_integracion,
  input  logic                     sync,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic [CH_W-1:0]          data_ch,
  input  logic                     data_valid,
  input  logic signed [REF_W-1:0]  ref_sen,
  input  logic signed [REF_W-1:0]  ref_cos,
  output logic signed [ACC_W-1:0]  out_fase,
  output logic signed [ACC_W-1:0]  out_cuad,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     lockin_ready,
  output logic                     processing_finished,
  output logic [31:0]              n_datos_promediados,
  output logic                     seq_err,
  output logic                     overrun
);

  localparam int               PROD_W    = DATA_W + REF_W;
  localparam logic [CH_W-1:0]  c_last_ch = CH_W'(NCH - 1);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_ACUM      = 3'd1,
    S_FLUSH     = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_m, r_n, r_pt, r_fr;
  logic                      r_cont, r_flush, r_seq_err, r_overrun;
  logic [CH_W-1:0]           r_exp_ch, r_k, r_ch1;
  logic [31:0]               r_ndat;
  logic                      r_v1, r_last1;
  logic signed [PROD_W-1:0]  r_p_s, r_p_c;
  logic                      w_beat, w_take, w_bad, w_set_done, w_clear, w_drop, w_fire;
  logic                      w_last_pt, w_last_fr;
  logic signed [ACC_W-1:0]   w_acc_f [NCH];
  logic signed [ACC_W-1:0]   w_acc_c [NCH];

  assign w_beat    = data_valid && enable;
  assign w_last_pt = (r_pt == r_m - c_one);
  assign w_last_fr = (r_fr == r_n - c_one);

  // Run configuration is captured while reset is held; zero counts act as one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m    <= (ptos_x_ciclo == '0) ? c_one : ptos_x_ciclo;
      r_n    <= (frames_integracion == '0) ? c_one : frames_integracion;
      r_cont <= mode_continuous;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_WAIT_SYNC;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode, beat classification and status outputs
  always_comb begin
    w_state_nxt         = r_state;
    w_take              = 1'b0;
    w_bad               = 1'b0;
    w_set_done          = 1'b0;
    w_clear             = 1'b0;
    w_drop              = 1'b0;
    w_fire              = 1'b0;
    out_valid           = 1'b0;
    lockin_ready        = 1'b0;
    processing_finished = 1'b0;
    case (r_state)
      S_WAIT_SYNC: begin
        lockin_ready = 1'b1;
        if (sync && enable) begin
          w_state_nxt = S_ACUM;
          w_clear     = 1'b1;
        end
      end
      S_ACUM: begin
        if (w_beat) begin
          if (data_ch != r_exp_ch) begin
            w_bad = 1'b1;
          end else begin
            w_take = 1'b1;
            if (r_exp_ch == c_last_ch) begin
              w_set_done = 1'b1;
              if (w_last_pt && w_last_fr) w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      // Two cycles for the final set to land in the accumulators; beats
      // here are already past the end of the run and count as overrun
      S_FLUSH: begin
        w_drop = w_beat;
        if (r_flush) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        w_drop    = w_beat;
        if (out_ready) begin
          w_fire = 1'b1;
          if (r_k == c_last_ch) begin
            if (r_cont) begin
              w_state_nxt = S_ACUM;
              w_clear     = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        processing_finished = 1'b1;
      end
      default: w_state_nxt = S_WAIT_SYNC;
    endcase
  end

  // Channel sequencing, point/frame counters, drain index and sticky flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exp_ch  <= '0;
      r_pt      <= '0;
      r_fr      <= '0;
      r_ndat    <= '0;
      r_k       <= '0;
      r_flush   <= 1'b0;
      r_seq_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_clear) begin
        r_exp_ch <= '0;
        r_pt     <= '0;
        r_fr     <= '0;
        r_ndat   <= '0;
      end else begin
        if (w_bad)       r_exp_ch <= '0;
        else if (w_take) r_exp_ch <= (r_exp_ch == c_last_ch) ? '0 : r_exp_ch + 1'b1;
        if (w_set_done) begin
          r_ndat <= r_ndat + 32'd1;
          if (w_last_pt) begin
            r_pt <= '0;
            r_fr <= w_last_fr ? '0 : r_fr + c_one;
          end else begin
            r_pt <= r_pt + c_one;
          end
        end
      end
      if (w_clear)     r_k <= '0;
      else if (w_fire) r_k <= (r_k == c_last_ch) ? '0 : r_k + 1'b1;
      r_flush <= (r_state == S_FLUSH) ? ~r_flush : 1'b0;
      if (w_bad)  r_seq_err <= 1'b1;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Stage 1: register both products with the channel tag and set-end marker
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_ch1   <= '0;
      r_p_s   <= '0;
      r_p_c   <= '0;
    end else begin
      r_v1    <= w_take;
      r_last1 <= w_take && (r_exp_ch == c_last_ch);
      if (w_take) begin
        r_ch1 <= data_ch;
        r_p_s <= PROD_W'(data_in) * PROD_W'(ref_sen);
        r_p_c <= PROD_W'(data_in) * PROD_W'(ref_cos);
      end
    end
  end

  // Stage 2: per-channel accumulation, committed once the whole set is in
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [PROD_W-1:0] w_add_s, w_add_c;
    logic signed [ACC_W-1:0]  r_acc_f, r_acc_c;

    if (g == NCH - 1) begin : g_direct
      assign w_add_s = r_p_s;
      assign w_add_c = r_p_c;
    end else begin : g_pend
      logic signed [PROD_W-1:0] r_pend_s, r_pend_c;
      // Park this channel's product until the closing beat of its set arrives
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_pend_s <= '0;
          r_pend_c <= '0;
        end else if (r_v1 && (r_ch1 == CH_W'(g))) begin
          r_pend_s <= r_p_s;
          r_pend_c <= r_p_c;
        end
      end
      assign w_add_s = r_pend_s;
      assign w_add_c = r_pend_c;
    end

    // Wrap-around accumulation of the sign-extended products
    always_ff @(posedge clk) begin
      if (!reset_n || w_clear) begin
        r_acc_f <= '0;
        r_acc_c <= '0;
      end else if (r_v1 && r_last1) begin
        r_acc_f <= r_acc_f + ACC_W'(w_add_s);
        r_acc_c <= r_acc_c + ACC_W'(w_add_c);
      end
    end

    assign w_acc_f[g] = r_acc_f;
    assign w_acc_c[g] = r_acc_c;
  end

  assign out_fase            = w_acc_f[r_k];
  assign out_cuad            = w_acc_c[r_k];
  assign out_ch              = r_k;
  assign n_datos_promediados = r_ndat;
  assign seq_err             = r_seq_err;
  assign overrun             = r_overrun;

endmodule
`default_nettype wire
